// File: rtl/io_bus_master_pkg.sv
`default_nettype none
// ============================================================================
// Module   : io_bus_master_pkg
// Brief    : Shared IO bus widths, control encoding, device field and FSM states.
// Revision : 1.0 - initial release
// ============================================================================
package io_bus_master_pkg;

  localparam int IO_BUS_WIDTH_ADDR = 32;
  localparam int IO_BUS_WIDTH_DATA = 32;
  localparam int IO_BUS_WIDTH_CTRL = 2;

  localparam int   IO_BUS_CTRL_WE = 0;
  localparam logic IO_CTRL_WRITE  = 1'b1;
  localparam logic IO_CTRL_READ   = 1'b0;

  localparam int IO_N_DEV  = 4;
  localparam int IO_DEV_HI = 11;
  localparam int IO_DEV_LO = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_RESP   = 2'd3
  } io_master_state_e;

endpackage : io_bus_master_pkg
`default_nettype wire

// File: rtl/io_bus_dev_decode.sv
`default_nettype none
// ============================================================================
// Module   : io_bus_dev_decode
// Brief    : Address to one-hot device grant, with a flag for unmapped devices.
// Revision : 1.0 - initial release
// ============================================================================
module io_bus_dev_decode
  import io_bus_master_pkg::*;
#(
  parameter int ADDR_W = IO_BUS_WIDTH_ADDR,
  parameter int N_DEV  = IO_N_DEV,
  parameter int DEV_HI = IO_DEV_HI,
  parameter int DEV_LO = IO_DEV_LO
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [N_DEV-1:0]  grant,
  output logic              unmapped
);

  localparam int DEV_W = DEV_HI - DEV_LO + 1;

  logic [DEV_W-1:0] w_dev;
  logic [31:0]      w_dev_idx;
  logic             w_unused;

  assign w_dev     = addr[DEV_HI:DEV_LO];
  assign w_dev_idx = 32'(w_dev);
  assign unmapped  = (w_dev_idx >= 32'(N_DEV));
  assign w_unused  = ^{addr[ADDR_W-1:DEV_HI+1], addr[DEV_LO-1:0]};

  // An unmapped index matches no grant line, so grant is all-zero then.
  for (genvar i = 0; i < N_DEV; i++) begin : g_grant
    assign grant[i] = (w_dev_idx == 32'(i));
  end

endmodule : io_bus_dev_decode
`default_nettype wire

// File: rtl/io_bus_master.sv
`default_nettype none
// ============================================================================
// Module   : io_bus_master
// Brief    : CPU-side initiator turning single loads/stores into IO bus cycles.
//            Optional busy-cycle counter enabled by IO_MASTER_PERF_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module io_bus_master
  import io_bus_master_pkg::*;
#(
  parameter int ADDR_W = IO_BUS_WIDTH_ADDR,
  parameter int DATA_W = IO_BUS_WIDTH_DATA,
  parameter int CTRL_W = IO_BUS_WIDTH_CTRL,
  parameter int N_DEV  = IO_N_DEV,
  parameter int DEV_HI = IO_DEV_HI,
  parameter int DEV_LO = IO_DEV_LO
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req_valid,
  output logic              cpu_req_ready,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_resp_valid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_err,
  output logic [N_DEV-1:0]  BG,
  output logic [ADDR_W-1:0] addr,
  output logic [CTRL_W-1:0] ctrl,
  inout  wire  [DATA_W-1:0] data
`ifdef IO_MASTER_PERF_CNT_EN
  ,
  input  logic              perf_clr,
  output logic [31:0]       busy_cycles
`endif
);

  io_master_state_e r_state;
  io_master_state_e w_state_nxt;

  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [N_DEV-1:0]  r_grant;
  logic [DATA_W-1:0] r_rdata;
  logic              r_err;

  logic [N_DEV-1:0]  w_grant;
  logic              w_unmapped;
  logic              w_bus_active;
  logic              w_drive;
  logic [CTRL_W-1:0] w_ctrl;

  io_bus_dev_decode #(
    .ADDR_W (ADDR_W),
    .N_DEV  (N_DEV),
    .DEV_HI (DEV_HI),
    .DEV_LO (DEV_LO)
  ) u_decode (
    .addr     (cpu_addr),
    .grant    (w_grant),
    .unmapped (w_unmapped)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    cpu_req_ready  = 1'b0;
    cpu_resp_valid = 1'b0;
    w_bus_active   = 1'b0;
    w_drive        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        cpu_req_ready = 1'b1;
        if (cpu_req_valid) begin
          w_state_nxt = w_unmapped ? ST_RESP : ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        w_bus_active = 1'b1;
        w_drive      = r_we;
        w_state_nxt  = r_we ? ST_RESP : ST_SAMPLE;
      end
      ST_SAMPLE: begin
        w_bus_active = 1'b1;
        w_state_nxt  = ST_RESP;
      end
      ST_RESP: begin
        cpu_resp_valid = 1'b1;
        w_state_nxt    = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_ctrl                 = '0;
    w_ctrl[IO_BUS_CTRL_WE] = r_we ? IO_CTRL_WRITE : IO_CTRL_READ;
    BG   = w_bus_active ? r_grant : '0;
    addr = w_bus_active ? r_addr  : '0;
    ctrl = w_bus_active ? w_ctrl  : '0;
  end

  assign data = w_drive ? r_wdata : {DATA_W{1'bz}};

  // Response registers only change on the edge entering RESP, so they hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_grant <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cpu_req_valid) begin
            r_we    <= cpu_we;
            r_addr  <= cpu_addr;
            r_wdata <= cpu_wdata;
            r_grant <= w_grant;
            if (w_unmapped) begin
              r_rdata <= '0;
              r_err   <= 1'b1;
            end
          end
        end
        ST_DRIVE: begin
          if (r_we) begin
            r_rdata <= '0;
            r_err   <= 1'b0;
          end
        end
        ST_SAMPLE: begin
          r_rdata <= data;
          r_err   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign cpu_rdata = r_rdata;
  assign cpu_err   = r_err;

`ifdef IO_MASTER_PERF_CNT_EN
  logic [31:0] r_busy_cycles;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy_cycles <= '0;
    end else if (perf_clr) begin
      r_busy_cycles <= '0;
    end else if (r_state != ST_IDLE) begin
      r_busy_cycles <= r_busy_cycles + 32'd1;
    end
  end

  assign busy_cycles = r_busy_cycles;
`endif

endmodule : io_bus_master
`default_nettype wire

// File: tb/tb_io_bus_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_io_bus_master
// Brief    : Directed scoreboard bench for io_bus_master with a bus keeper and
//            a registered-read device model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_io_bus_master;

  localparam logic [31:0] KEEP = 32'hC0DE_0F0F;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          accept;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req_valid;
  logic        cpu_req_ready;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_resp_valid;
  logic [31:0] cpu_rdata;
  logic        cpu_err;
  logic [3:0]  BG;
  logic [31:0] addr;
  logic [1:0]  ctrl;
  wire  [31:0] data;
`ifdef IO_MASTER_PERF_CNT_EN
  logic        perf_clr;
  logic [31:0] busy_cycles;
`endif

  int          n_chk  = 0;
  int          n_pass = 0;
  int          cyc    = 0;
  int          last_accept = 0;
  exp_t        sb[$];
  logic [31:0] dev_rdata = 32'h0;
  logic        r_dev_en;
  logic        w_keep;

  io_bus_master u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cpu_req_valid  (cpu_req_valid),
    .cpu_req_ready  (cpu_req_ready),
    .cpu_we         (cpu_we),
    .cpu_addr       (cpu_addr),
    .cpu_wdata      (cpu_wdata),
    .cpu_resp_valid (cpu_resp_valid),
    .cpu_rdata      (cpu_rdata),
    .cpu_err        (cpu_err),
    .BG             (BG),
    .addr           (addr),
    .ctrl           (ctrl),
    .data           (data)
`ifdef IO_MASTER_PERF_CNT_EN
    ,
    .perf_clr       (perf_clr),
    .busy_cycles    (busy_cycles)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Device answers a read one cycle after being granted; keeper fills idle bus.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_dev_en <= 1'b0;
    else        r_dev_en <= (BG != 4'b0) && (ctrl[0] == 1'b0) && !r_dev_en;
  end
  assign w_keep = !((BG != 4'b0) && (ctrl[0] == 1'b1)) && !r_dev_en;
  assign data   = w_keep ? KEEP : (r_dev_en ? dev_rdata : 32'bz);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  task automatic issue(input logic we, input logic [31:0] a, input logic [31:0] wd);
    exp_t e;
    bit   done = 1'b0;
    cpu_req_valid = 1'b1;
    cpu_we        = we;
    cpu_addr      = a;
    cpu_wdata     = wd;
    for (int i = 0; i < 20 && !done; i++) begin
      if (cpu_req_ready) begin
        e.err    = (a[11:8] >= 4'd4);
        e.rdata  = (we || e.err) ? 32'h0 : dev_rdata;
        e.lat    = e.err ? 1 : (we ? 2 : 3);
        e.accept = cyc + 1;
        last_accept = e.accept;
        sb.push_back(e);
        done = 1'b1;
      end
      @(negedge clk);
    end
    chk("accept_timeout", 32'(done), 32'd1);
  endtask

  task automatic drain();
    bit ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && cpu_req_ready) ok = 1'b1;
    end
    chk("drain_timeout", 32'(ok), 32'd1);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      chk("bg_onehot0", 32'($onehot0(BG)), 32'd1);
      if (cpu_resp_valid) begin
        if (sb.size() == 0) begin
          chk("resp_sb_size", 32'(sb.size()), 32'd1);
        end else begin
          e = sb.pop_front();
          chk("resp_rdata", cpu_rdata, e.rdata);
          chk("resp_err", 32'(cpu_err), 32'(e.err));
          chk("resp_latency", 32'(cyc + 1 - e.accept), 32'(e.lat));
        end
      end
    end
  end

  initial begin
    int first_accept;
    rst_n = 1'b0; cpu_req_valid = 1'b0; cpu_we = 1'b0;
    cpu_addr = 32'h0; cpu_wdata = 32'h0;
`ifdef IO_MASTER_PERF_CNT_EN
    perf_clr = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_bg", 32'(BG), 32'h0);
    chk("rst_addr", addr, 32'h0);
    chk("rst_ctrl", 32'(ctrl), 32'h0);
    chk("rst_data_z", data, KEEP);
    chk("rst_ready", 32'(cpu_req_ready), 32'd1);
    chk("rst_resp_valid", 32'(cpu_resp_valid), 32'd0);
    chk("rst_rdata", cpu_rdata, 32'h0);
    chk("rst_err", 32'(cpu_err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Store to device 1
    issue(1'b1, 32'h0000_0100, 32'h0000_00A5);
    cpu_req_valid = 1'b0;
    chk("st_drive_bg", 32'(BG), 32'h2);
    chk("st_drive_we", 32'(ctrl[0]), 32'd1);
    chk("st_drive_addr", addr, 32'h0000_0100);
    chk("st_drive_data", data, 32'h0000_00A5);
    chk("st_drive_ready", 32'(cpu_req_ready), 32'd0);
    @(negedge clk);
    chk("st_resp_bg", 32'(BG), 32'h0);
    chk("st_resp_data_z", data, KEEP);
    drain();

    // Load from device 1
    dev_rdata = 32'h0000_3C3C;
    issue(1'b0, 32'h0000_0100, 32'hFFFF_0000);
    cpu_req_valid = 1'b0;
    chk("ld_drive_bg", 32'(BG), 32'h2);
    chk("ld_drive_we", 32'(ctrl[0]), 32'd0);
    chk("ld_drive_data_z", data, KEEP);
    @(negedge clk);
    chk("ld_sample_bg", 32'(BG), 32'h2);
    chk("ld_sample_data", data, 32'h0000_3C3C);
    drain();
    @(negedge clk);
    chk("ld_rdata_hold", cpu_rdata, 32'h0000_3C3C);

    // Unmapped device 5
    issue(1'b0, 32'h0000_0500, 32'h0);
    cpu_req_valid = 1'b0;
    chk("err_bg", 32'(BG), 32'h0);
    chk("err_resp_valid", 32'(cpu_resp_valid), 32'd1);
    drain();
    @(negedge clk);
    chk("err_hold", 32'(cpu_err), 32'd1);

    // Back-to-back store then load with valid held high
    dev_rdata = 32'h1234_8765;
    issue(1'b1, 32'h0000_0200, 32'h0000_5AA5);
    first_accept = last_accept;
    chk("b2b_st_bg", 32'(BG), 32'h4);
    issue(1'b0, 32'h0000_0300, 32'hFFFF_0000);
    cpu_req_valid = 1'b0;
    chk("b2b_spacing", 32'(last_accept - first_accept), 32'd3);
    chk("b2b_ld_bg", 32'(BG), 32'h8);
    chk("b2b_ld_data_z", data, KEEP);
    @(negedge clk);
    chk("b2b_ld_sample", data, 32'h1234_8765);
    drain();

    // Reset in the middle of a load
    dev_rdata = 32'h0000_3C3C;
    issue(1'b0, 32'h0000_0100, 32'hFFFF_0000);
    cpu_req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("mid_rst_bg", 32'(BG), 32'h0);
    chk("mid_rst_data_z", data, KEEP);
    chk("mid_rst_ready", 32'(cpu_req_ready), 32'd1);
    chk("mid_rst_rdata", cpu_rdata, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("mid_rst_no_resp", 32'(cpu_resp_valid), 32'd0);
    end

`ifdef IO_MASTER_PERF_CNT_EN
    perf_clr = 1'b1;
    @(negedge clk);
    perf_clr = 1'b0;
    chk("perf_clr0", busy_cycles, 32'h0);
    issue(1'b1, 32'h0000_0000, 32'h0000_0011);
    cpu_req_valid = 1'b0;
    drain();
    issue(1'b0, 32'h0000_0000, 32'h0);
    cpu_req_valid = 1'b0;
    drain();
    chk("perf_busy", busy_cycles, 32'd5);
    perf_clr = 1'b1;
    @(negedge clk);
    perf_clr = 1'b0;
    chk("perf_clr1", busy_cycles, 32'h0);
`endif

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule : tb_io_bus_master
`default_nettype wire
